// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encoding and counter sizing helpers.
package pll_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_CNT_W         = 8;

    // Bits needed to count 0..max(a,b)-1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Multi-stage bit synchroniser with async active-low clear.
// Output is the last stage of the shift chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and sequences the downstream system reset.
// Counts lock losses seen while running for debug.
module pll_reset_sequencer
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             clear_stats,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             lock_lost_sticky,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    pll_state_e     state;
    pll_state_e     state_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    logic           lk;
    logic           lost_evt;
    logic           run_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            run_q <= (state_nx == RUN);
        end
    end

    // One shared counter serves both qualification phases.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lost_evt = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (lk) begin
                    state_nx = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    lost_evt = 1'b1;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
        endcase
    end

    // A clear in the same cycle as a loss event takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_sticky <= 1'b0;
            lock_lost_cnt    <= '0;
        end else if (clear_stats) begin
            lock_lost_sticky <= 1'b0;
            lock_lost_cnt    <= '0;
        end else if (lost_evt) begin
            lock_lost_sticky <= 1'b1;
            if (lock_lost_cnt != CNT_MAX) begin
                lock_lost_cnt <= lock_lost_cnt + 1'b1;
            end
        end
    end

    assign sys_rst_n = run_q;
    assign ready     = run_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: lock-streak model plus directed
// scenarios with literal release/fall latencies.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLDC  = 4;
    localparam int CW     = 2;
    localparam int RELEASE_EDGES = STABLE + HOLDC + 1;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          clear_stats;
    logic          sys_rst_n;
    logic          ready;
    logic          lock_lost_sticky;
    logic [CW-1:0] lock_lost_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLDC),
        .CNT_W         (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_locked       (pll_locked),
        .clear_stats      (clear_stats),
        .sys_rst_n        (sys_rst_n),
        .ready            (ready),
        .lock_lost_sticky (lock_lost_sticky),
        .lock_lost_cnt    (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    // Model: release after RELEASE_EDGES consecutive edges with synced lock.
    logic [SYNC-1:0] m_pipe   = '0;
    int              m_streak = 0;
    bit              m_run    = 1'b0;
    int              m_cnt    = 0;
    bit              m_sticky = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe   <= '0;
            m_streak <= 0;
            m_run    <= 1'b0;
            m_cnt    <= 0;
            m_sticky <= 1'b0;
        end else begin
            m_pipe <= {m_pipe[SYNC-2:0], pll_locked};
            if (m_run) begin
                if (!m_pipe[SYNC-1]) begin
                    m_run    <= 1'b0;
                    m_streak <= 0;
                end
            end else if (m_pipe[SYNC-1]) begin
                if (m_streak + 1 == RELEASE_EDGES) begin
                    m_run    <= 1'b1;
                    m_streak <= 0;
                end else begin
                    m_streak <= m_streak + 1;
                end
            end else begin
                m_streak <= 0;
            end
            if (clear_stats) begin
                m_cnt    <= 0;
                m_sticky <= 1'b0;
            end else if (m_run && !m_pipe[SYNC-1]) begin
                m_sticky <= 1'b1;
                m_cnt    <= (m_cnt == CNT_SAT) ? CNT_SAT : m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_sys_rst_n", int'(sys_rst_n), int'(m_run));
        chk("model_ready", int'(ready), int'(m_run));
        chk("model_sticky", int'(lock_lost_sticky), int'(m_sticky));
        chk("model_cnt", int'(lock_lost_cnt), m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sys_rst_n && n < 200);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sys_rst_n && n < 200);
    endtask

    int n;

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b1;
        clear_stats = 1'b0;
        repeat (3) step();

        chk("rst_sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_cnt", int'(lock_lost_cnt), 0);
        chk("rst_sticky", int'(lock_lost_sticky), 0);

        // 1: release from reset with lock already present
        rst_n = 1'b1;
        wait_release(n);
        chk("t1_release_edges", n, SYNC + RELEASE_EDGES);

        // 2: glitch during STABILIZE (cnt=5 after 8 edges)
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();
        pll_locked = 1'b0;
        repeat (3) step();
        chk("t2_still_reset", int'(sys_rst_n), 0);
        pll_locked = 1'b1;
        wait_release(n);
        chk("t2_release_edges", n, 15);
        chk("t2_cnt", int'(lock_lost_cnt), 0);

        // 3: loss of lock in RUN
        pll_locked = 1'b0;
        wait_fall(n);
        chk("t3_fall_edges", n, 3);
        chk("t3_cnt", int'(lock_lost_cnt), 1);
        chk("t3_sticky", int'(lock_lost_sticky), 1);
        pll_locked = 1'b1;
        wait_release(n);
        chk("t3_rerelease_edges", n, 15);

        // 4: saturate the loss counter, then clear
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            wait_fall(n);
            chk("t4_fall_edges", n, 3);
            pll_locked = 1'b1;
            wait_release(n);
            chk("t4_release_edges", n, 15);
        end
        chk("t4_cnt_sat", int'(lock_lost_cnt), 3);
        chk("t4_sticky", int'(lock_lost_sticky), 1);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("t4_clr_cnt", int'(lock_lost_cnt), 0);
        chk("t4_clr_sticky", int'(lock_lost_sticky), 0);

        // 5: clear coincident with a RUN loss
        pll_locked = 1'b0;
        repeat (2) step();
        chk("t5_pre_fall", int'(sys_rst_n), 1);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("t5_sys_rst_n", int'(sys_rst_n), 0);
        chk("t5_cnt", int'(lock_lost_cnt), 0);
        chk("t5_sticky", int'(lock_lost_sticky), 0);
        pll_locked = 1'b1;
        wait_release(n);
        chk("t5_release_edges", n, 15);

        // 6: async reset while in HOLD
        pll_locked = 1'b0;
        wait_fall(n);
        chk("t6_fall_edges", n, 3);
        pll_locked = 1'b1;
        repeat (12) step();
        chk("t6_pre_sys", int'(sys_rst_n), 0);
        chk("t6_pre_cnt", int'(lock_lost_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_sys", int'(sys_rst_n), 0);
        chk("t6_async_cnt", int'(lock_lost_cnt), 0);
        chk("t6_async_sticky", int'(lock_lost_sticky), 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_release(n);
        chk("t6_release_edges", n, SYNC + RELEASE_EDGES);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
